// File: rtl/mem_arbiter.sv
// Two-client line arbiter: instruction and data caches share one downstream memory port.
// One transaction in flight; ties in IDLE alternate via last_grant.
//
// state   | meaning
// IDLE    | no downstream strobe; arbitrate pending I/D requests
// SERVE_I | instruction-cache line read outstanding downstream
// SERVE_D | data-cache read or writeback outstanding downstream
module mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_grant_d;
    logic                  last_grant_d_next;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [LINE_WIDTH-1:0] hold_wdata;
    logic                  hold_write;
    logic                  i_req;
    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_next        = state;
        last_grant_d_next = last_grant_d;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        i_pmem_resp       = 1'b0;
        d_pmem_resp       = 1'b0;
        case (state)
            IDLE: begin
                // On a tie D wins unless D was the last one served.
                if (d_req && (!i_req || !last_grant_d)) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_pmem_resp       = 1'b1;
                    last_grant_d_next = 1'b0;
                    state_next        = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read  = ~hold_write;
                pmem_write = hold_write;
                if (pmem_resp) begin
                    d_pmem_resp       = 1'b1;
                    last_grant_d_next = 1'b1;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            hold_addr    <= '0;
            hold_wdata   <= '0;
            hold_write   <= 1'b0;
        end else begin
            state        <= state_next;
            last_grant_d <= last_grant_d_next;
            if (grant_i) begin
                hold_addr  <= i_pmem_address;
                hold_write <= 1'b0;
            end
            if (grant_d) begin
                // A combined read+write request is the writeback half of a miss.
                hold_addr  <= d_pmem_address;
                hold_write <= d_pmem_write;
                if (d_pmem_write) begin
                    hold_wdata <= d_pmem_wdata;
                end
            end
        end
    end

    assign pmem_address = hold_addr;
    assign pmem_wdata   = hold_wdata;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter: each row holds one cycle's inputs
// and the outputs expected during that cycle.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ir, dr, dw;
        logic [31:0] ia, da, dwd;
        logic        pr;
        logic [31:0] prd;
        logic        erd, ewr;
        logic [31:0] eaddr, ewd;
        logic        eir, edr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = -1;

    task automatic add(input logic rs, input logic ir, input logic dr, input logic dw,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                       input logic pr, input logic [31:0] prd,
                       input logic erd, input logic ewr, input logic [31:0] eaddr,
                       input logic [31:0] ewd, input logic eir, input logic edr);
        vec_t v;
        v.rst = rs; v.ir = ir; v.dr = dr; v.dw = dw;
        v.ia = ia; v.da = da; v.dwd = dwd; v.pr = pr; v.prd = prd;
        v.erd = erd; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd; v.eir = eir; v.edr = edr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        // I read 0x40 alone, resp after 3 cycles
        add(0,1,0,0,'h40,0,0,                 0,0,           0,0,0,0,0,0);
        add(0,0,0,0,'h40,0,0,                 0,0,           1,0,'h40,0,0,0);
        add(0,0,0,0,'h40,0,0,                 0,0,           1,0,'h40,0,0,0);
        add(0,0,0,0,'h40,0,0,                 1,'hAAAAAAAA,  1,0,'h40,0,1,0);
        // D write 0x1000, inputs change mid-service
        add(0,0,0,1,0,'h1000,'h55555555,      0,0,           0,0,0,0,0,0);
        add(0,0,0,1,0,'h1000,'h55555555,      0,0,           0,1,'h1000,'h55555555,0,0);
        add(0,0,0,1,0,'h2000,'h33333333,      0,0,           0,1,'h1000,'h55555555,0,0);
        add(0,0,0,1,0,'h2000,'h33333333,      1,'h12345678,  0,1,'h1000,'h55555555,0,1);
        add(0,0,0,0,0,0,0,                    0,0,           0,0,0,0,0,0);
        // reset, then both held: D, I, D, I
        add(1,0,0,0,0,0,0,                    0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h100,'h200,0,            0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h100,'h200,0,            1,'hC3C3C3C3,  1,0,'h200,0,0,1);
        add(0,1,1,0,'h100,'h200,0,            0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h100,'h200,0,            1,'h0F0F0F0F,  1,0,'h100,0,1,0);
        add(0,1,1,0,'h100,'h200,0,            0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h100,'h200,0,            1,'hDEADBEEF,  1,0,'h200,0,0,1);
        add(0,1,1,0,'h100,'h200,0,            0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h100,'h200,0,            1,'h5A5A5A5A,  1,0,'h100,0,1,0);
        add(0,0,0,0,0,0,0,                    0,0,           0,0,0,0,0,0);
        // D read drops request and changes address mid-service
        add(0,0,1,0,0,'h300,0,                0,0,           0,0,0,0,0,0);
        add(0,0,0,0,0,'h999,0,                0,0,           1,0,'h300,0,0,0);
        add(0,0,0,0,0,'h888,0,                1,'h77777777,  1,0,'h300,0,0,1);
        // stray resp in IDLE is ignored
        add(0,0,0,0,0,0,0,                    1,'h11111111,  0,0,0,0,0,0);
        // reset during SERVE_I, late resp, then tie goes to D
        add(0,1,0,0,'h500,0,0,                0,0,           0,0,0,0,0,0);
        add(1,0,0,0,'h500,0,0,                0,0,           1,0,'h500,0,0,0);
        add(0,0,0,0,0,0,0,                    1,'h22222222,  0,0,0,0,0,0);
        add(0,1,1,0,'h600,'h700,0,            0,0,           0,0,0,0,0,0);
        add(0,1,1,0,'h600,'h700,0,            1,'h44444444,  1,0,'h700,0,0,1);
        // read+write together is a write
        add(0,0,1,1,0,'h800,'hA5A5A5A5,       0,0,           0,0,0,0,0,0);
        add(0,0,1,1,0,'h800,'hA5A5A5A5,       1,'h66666666,  0,1,'h800,'hA5A5A5A5,0,1);
        add(0,0,0,0,0,0,0,                    0,0,           0,0,0,0,0,0);

        rst = 1'b1; i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_read",  LW'(pmem_read),   '0);
        chk("reset_write", LW'(pmem_write),  '0);
        chk("reset_iresp", LW'(i_pmem_resp), '0);
        chk("reset_dresp", LW'(d_pmem_resp), '0);
        chk("reset_addr",  LW'(pmem_address), '0);
        chk("reset_wdata", pmem_wdata,        '0);

        foreach (vecs[k]) begin
            @(negedge clk);
            row            = k;
            rst            = vecs[k].rst;
            i_pmem_read    = vecs[k].ir;
            i_pmem_address = vecs[k].ia;
            d_pmem_read    = vecs[k].dr;
            d_pmem_write   = vecs[k].dw;
            d_pmem_address = vecs[k].da;
            d_pmem_wdata   = {8{vecs[k].dwd}};
            pmem_resp      = vecs[k].pr;
            pmem_rdata     = {8{vecs[k].prd}};
            #1;
            chk("pmem_read",   LW'(pmem_read),   LW'(vecs[k].erd));
            chk("pmem_write",  LW'(pmem_write),  LW'(vecs[k].ewr));
            chk("i_resp",      LW'(i_pmem_resp), LW'(vecs[k].eir));
            chk("d_resp",      LW'(d_pmem_resp), LW'(vecs[k].edr));
            chk("i_rdata",     i_pmem_rdata,     {8{vecs[k].prd}});
            chk("d_rdata",     d_pmem_rdata,     {8{vecs[k].prd}});
            if (vecs[k].erd || vecs[k].ewr)
                chk("pmem_address", LW'(pmem_address), LW'(vecs[k].eaddr));
            if (vecs[k].ewr)
                chk("pmem_wdata", pmem_wdata, {8{vecs[k].ewd}});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, default 256, cache line width in bits for all data buses.
REQ-002 Parameter: ADDR_WIDTH, default 32, physical address width.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: i_pmem_read  in  1  instruction-cache line read request.
REQ-006 Port: i_pmem_address  in  ADDR_WIDTH  instruction-cache line address.
REQ-007 Port: i_pmem_rdata  out  LINE_WIDTH  read line returned to the instruction cache.
REQ-008 Port: i_pmem_resp  out  1  instruction-cache transaction complete.
REQ-009 Port: d_pmem_read  in  1  data-cache line read request.
REQ-010 Port: d_pmem_write  in  1  data-cache line writeback request.
REQ-011 Port: d_pmem_address  in  ADDR_WIDTH  data-cache line address.
REQ-012 Port: d_pmem_wdata  in  LINE_WIDTH  data-cache writeback line.
REQ-013 Port: d_pmem_rdata  out  LINE_WIDTH  read line returned to the data cache.
REQ-014 Port: d_pmem_resp  out  1  data-cache transaction complete.
REQ-015 Port: pmem_read, pmem_write  out  1 each  downstream line read/write strobes.
REQ-016 Port: pmem_address  out  ADDR_WIDTH; pmem_wdata  out  LINE_WIDTH  downstream request.
REQ-017 Port: pmem_rdata  in  LINE_WIDTH; pmem_resp  in  1  downstream completion.

Function
REQ-018 FSM states: IDLE, SERVE_I, SERVE_D; exactly one transaction outstanding downstream at any time.
REQ-019 IDLE: no downstream strobe asserted; i_pmem_resp and d_pmem_resp are 0.
REQ-020 IDLE with only an I request -> SERVE_I next cycle; only a D request (read or write) -> SERVE_D next cycle.
REQ-021 IDLE with both requesting: round-robin; grant the requester not served last (last_grant register); last_grant resets to I, so D wins the first tie.
REQ-022 On grant, latch requester address, read/write kind, and (for D write) wdata into holding registers; downstream outputs drive from the holding registers only.
REQ-023 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=latched I address.
REQ-024 SERVE_D: pmem_read or pmem_write per the latched kind, with pmem_address and pmem_wdata latched.
REQ-025 d_pmem_read and d_pmem_write asserted together: treat as a write (writeback precedes refill).
REQ-026 Strobes stay asserted, unchanged, until pmem_resp; requester inputs changing or dropping mid-service are ignored.
REQ-027 pmem_resp in SERVE_x: assert x_pmem_resp combinationally in that same cycle; pass pmem_rdata to x_pmem_rdata; next state IDLE; update last_grant to x.
REQ-028 The non-granted requester's resp stays 0 throughout; its rdata output is don't-care but is driven from pmem_rdata.
REQ-029 Minimum spacing: back-to-back transactions have exactly one IDLE cycle between them; a requester deasserts its request the cycle after its resp.
REQ-030 pmem_resp in IDLE: ignored; no resp forwarded, no state change.
REQ-031 Latency: request seen in IDLE at cycle N -> downstream strobe at N+1 -> resp in the same cycle as pmem_resp.

Reset
REQ-032 rst=1 at an edge: state IDLE, last_grant=I, holding registers cleared to 0, all strobes and resps 0 the following cycle.
REQ-033 rst mid-transaction abandons it: strobes drop next cycle; a pmem_resp arriving after reset is ignored per REQ-030.

Verification
REQ-034 I read 0x0000_0040 alone, pmem_resp after 3 cycles with line 0xAA..AA -> pmem_read at N+1, i_pmem_resp=1 with 0xAA..AA, d_pmem_resp stays 0.
REQ-035 D write 0x0000_1000 with wdata 0x55..55 -> pmem_write=1, address and wdata held stable until pmem_resp; d_pmem_resp pulses one cycle.
REQ-036 Both request after reset -> D served first; I served next after one IDLE cycle; swap both held again -> order alternates D, I, D, I.
REQ-037 D drops d_pmem_read and changes d_pmem_address mid-service -> pmem_address keeps the latched value until resp.
REQ-038 rst asserted during SERVE_I, then a late pmem_resp -> no i_pmem_resp; state IDLE; the next tie grants D.
REQ-039 d_pmem_read=d_pmem_write=1 -> pmem_write=1, pmem_read=0.
